// File: rtl/alu_arbitro_if.sv
// Bundle of requester, ALU-side and response signals for alu_arbitro.
// master: requester logic plus ALU wrapper (drives requests and ALU results).
// slave:  the arbitration controller (drives grants, ALU operands and responses).
interface alu_arbitro_if #(
    parameter int n = 4
);
    // Requester A
    logic         a_valid;
    logic [n-1:0] a_entrada1;
    logic [n-1:0] a_entrada2;
    logic [3:0]   a_selector;
    logic         a_ready;
    // Requester B
    logic         b_valid;
    logic [n-1:0] b_entrada1;
    logic [n-1:0] b_entrada2;
    logic [3:0]   b_selector;
    logic         b_ready;
    // ALU side
    logic [n-1:0] alu_entrada1;
    logic [n-1:0] alu_entrada2;
    logic [3:0]   alu_selector;
    logic [n-1:0] alu_resultado;
    logic [3:0]   alu_flags;      // {carry, cero, negativo, desbordamiento}
    // Response
    logic         resp_valid;
    logic         resp_id;        // 0 = A, 1 = B
    logic [n-1:0] resp_resultado;
    logic [3:0]   resp_flags;
    logic         ocupado;

    modport master (
        output a_valid, a_entrada1, a_entrada2, a_selector,
        output b_valid, b_entrada1, b_entrada2, b_selector,
        output alu_resultado, alu_flags,
        input  a_ready, b_ready,
        input  alu_entrada1, alu_entrada2, alu_selector,
        input  resp_valid, resp_id, resp_resultado, resp_flags, ocupado
    );

    modport slave (
        input  a_valid, a_entrada1, a_entrada2, a_selector,
        input  b_valid, b_entrada1, b_entrada2, b_selector,
        input  alu_resultado, alu_flags,
        output a_ready, b_ready,
        output alu_entrada1, alu_entrada2, alu_selector,
        output resp_valid, resp_id, resp_resultado, resp_flags, ocupado
    );
endinterface

// File: rtl/alu_arbitro.sv
// Purpose: shares one registered ALU between requesters A and B; arbitrates, issues operands, returns result.
// Latency: accept at E0, result captured at E0+LAT+1, resp_valid strobes the following cycle; one op per LAT+3 cycles.
// Backpressure: a_ready/b_ready only in IDLE; the losing requester must hold its valid, nothing is queued.
//
// Ports: clock, reset (async active-low), bus (alu_arbitro_if.slave) carrying both requester
// channels, ALU operand/result signals and the response strobe.
// Build option: define ALU_ARBITRO_ROUND_ROBIN_EN for round-robin arbitration; otherwise A has fixed priority.
module alu_arbitro #(
    parameter int n   = 4,
    parameter int LAT = 2
) (
    input  logic          clock,
    input  logic          reset,
    alu_arbitro_if.slave  bus
);
    localparam int CW = $clog2(LAT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic            grant_a;
    logic            grant_b;
    logic            accept;
    logic            prefer_b;

`ifdef ALU_ARBITRO_ROUND_ROBIN_EN
    // ptr = 1 favours B on a tie; after every accept it points at the requester not served.
    logic ptr;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr <= 1'b0;
        end else if (accept) begin
            ptr <= grant_a;
        end
    end

    assign prefer_b = ptr;
`else
    assign prefer_b = 1'b0;
`endif

    // Grants are combinational so a lone request is taken in the same cycle it appears.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (state == IDLE) begin
            if (bus.a_valid && (!bus.b_valid || !prefer_b)) begin
                grant_a = 1'b1;
            end else if (bus.b_valid) begin
                grant_b = 1'b1;
            end
        end
    end

    assign accept      = grant_a | grant_b;
    assign bus.a_ready = grant_a;
    assign bus.b_ready = grant_b;

    // FSM state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state and state-decoded outputs
    always_comb begin
        state_nxt      = state;
        bus.resp_valid = 1'b0;
        bus.ocupado    = 1'b1;
        case (state)
            IDLE: begin
                bus.ocupado = 1'b0;
                if (accept) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                // Counter reaching zero means the ALU output flops hold this operation's result.
                if (cnt == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                bus.resp_valid = 1'b1;
                state_nxt      = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Latency counter: loaded with LAT at accept, one decrement per WAIT edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= CW'(LAT);
        end else if (state == WAIT && cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    // Operand issue: requester fields are sampled only on the accept edge and held after.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus.alu_entrada1 <= '0;
            bus.alu_entrada2 <= '0;
            bus.alu_selector <= '0;
            bus.resp_id      <= 1'b0;
        end else if (accept) begin
            bus.alu_entrada1 <= grant_b ? bus.b_entrada1 : bus.a_entrada1;
            bus.alu_entrada2 <= grant_b ? bus.b_entrada2 : bus.a_entrada2;
            bus.alu_selector <= grant_b ? bus.b_selector : bus.a_selector;
            bus.resp_id      <= grant_b;
        end
    end

    // Result capture on the last WAIT edge; held until the next capture.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus.resp_resultado <= '0;
            bus.resp_flags     <= '0;
        end else if (state == WAIT && cnt == '0) begin
            bus.resp_resultado <= bus.alu_resultado;
            bus.resp_flags     <= bus.alu_flags;
        end
    end

endmodule

// File: doc/alu_arbitro.md
# alu_arbitro

Controller that shares one registered ALU datapath (input flip-flops, ALU, output flip-flops) between two requesters, A and B. It arbitrates between them, issues the accepted operands and selector to the ALU, and counts the fixed pipeline latency. It then captures the result and flags and returns them to the winning requester with a one-cycle response strobe. It sits between the requester logic and the ALU timing wrapper.

## Interface
- n, default 4: operand/result width.
- LAT, default 2: ALU pipeline latency in clock edges from operands presented to result valid. Legal range is LAT ≥ 1.

Clock and reset: one clock; reset is asynchronous and active-low.
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; clears all state.

Requester A:
- a_valid  in  1  request from A.
- a_entrada1  in  n  operand 1.
- a_entrada2  in  n  operand 2.
- a_selector  in  4  ALU operation.
- a_ready  out  1  grant to A; the transfer occurs on an edge where a_valid && a_ready.

Requester B:
- b_valid, b_entrada1, b_entrada2, b_selector, b_ready: same widths and rules as A.

ALU side:
- alu_entrada1  out  n  operand 1 to the ALU.
- alu_entrada2  out  n  operand 2 to the ALU.
- alu_selector  out  4  operation to the ALU.
- alu_resultado  in  n  ALU result.
- alu_flags  in  4  {carry, cero, negativo, desbordamiento}.

Response:
- resp_valid  out  1  one-cycle response strobe.
- resp_id  out  1  0 = A, 1 = B.
- resp_resultado  out  n  captured result.
- resp_flags  out  4  captured flags.
- ocupado  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, WAIT, DONE.

IDLE:
- a_ready and b_ready are combinational. At most one is high, and only for a requester whose valid is high.
- Only one valid is high: that requester is granted.
- Both valids are high: the priority rule decides (see Configuration).
- On the accept edge:
  - alu_entrada1, alu_entrada2 and alu_selector load the granted requester's fields.
  - resp_id is latched.
  - The counter loads LAT.
  - The FSM moves to WAIT.
- No valid high: stay in IDLE; both readies are low.

WAIT:
- Both readies are low.
- The counter decrements on each edge.
- On the edge where the counter equals 0: resp_resultado ← alu_resultado, resp_flags ← alu_flags, and the FSM moves to DONE.

DONE:
- resp_valid is high for exactly this one cycle.
- The FSM unconditionally moves to IDLE on the next edge.
- Readies are low in DONE.

General rules:
- alu_entrada1, alu_entrada2 and alu_selector hold their last issued values until the next accept.
- resp_resultado, resp_flags and resp_id hold their values until the next capture.
- The counter width is $clog2(LAT+1).
- Requester fields are sampled only at the accept edge. Later changes while in WAIT do not affect the operation in flight.
- A request that is still valid when the FSM returns to IDLE is arbitrated normally.

## Timing
- Reset values (reset low, asynchronous): state = IDLE, every output = 0, counter = 0, round-robin pointer favours A.
- Latency: accept at edge E0; ALU input flops capture at E1; result is valid after E0+LAT; the controller captures at E0+LAT+1; resp_valid is high in the cycle following that edge.
- Throughput: one operation per LAT+3 cycles. The earliest next accept is the edge ending the first IDLE cycle after DONE.
- Reset asserted mid-operation (WAIT or DONE): the operation is dropped and no resp_valid is produced. After reset deasserts, the block is in IDLE with the pointer favouring A.
- Simultaneous requests are resolved in the same cycle. The loser's valid must be held by the requester; no request is queued internally.

## Configuration
- ALU_ARBITRO_ROUND_ROBIN_EN defined:
  - Round-robin arbitration.
  - The 1-bit pointer flips to favour the non-granted requester after every accept.
  - When both valids are high, the favoured requester wins.
- ALU_ARBITRO_ROUND_ROBIN_EN undefined:
  - Fixed priority: A always wins when both valids are high.
  - No pointer register is built.
  - B can starve while a_valid stays high.

## Test plan
- Single op, n=4, LAT=2, round-robin on: a_valid with 4'd3, 4'd5, add selector accepted at E0 → resp_valid in the cycle after E3, resp_id=0, resp_resultado=4'd8, carry=0, cero=0.
- Simultaneous requests, round-robin on: a_valid and b_valid both held high after reset → grants A, B, A, B; resp_id alternates 0, 1, 0, 1; each response arrives LAT+3 cycles after the previous one.
- Fixed priority, macro undefined: a_valid and b_valid both held high → A is granted on every accept and b_ready stays 0. Dropping a_valid → B is granted at the next IDLE.
- Reset mid-op: reset pulsed low during WAIT → all outputs are 0 immediately, no resp_valid occurs, and ocupado=0. A following B request is granted first (pointer favours A only if a_valid is also high).
- Operand stability: A accepted, then a_entrada1 changed during WAIT → alu_entrada1 and resp_resultado reflect the accepted values; no ready is asserted during WAIT or DONE.
- LAT=1 parameter: 4'hF + 4'h1 → resp_valid in the cycle after E2, resp_resultado=0, carry=1, cero=1.
